// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receiver. Deserialises frames from RXD into a
//               first-word-fall-through FIFO and reports sticky framing,
//               overrun and (optionally) parity errors. UART_INT is a
//               registered level interrupt raised while data or errors
//               are pending.
//               Optional feature macro: UART_RX_PARITY_EN
//                 undefined -> 8N1 frames, PAR_ERR tied to 0
//                 defined   -> start, 8 data, even parity, stop
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    input  logic       RD_EN,
    output logic [7:0] RD_DATA,
    output logic       RX_VALID,
    input  logic       INT_EN,
    input  logic       CLR_ERR,
    output logic       OVERRUN,
    output logic       FRAME_ERR,
    output logic       PAR_ERR,
    output logic       UART_INT
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic             rx_meta_q;
    logic             rxs_q;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    logic             push;
    logic             frame_set;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             ovr_set;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ovr_q, ovr_d;
    logic             fe_q, fe_d;
    logic             int_q;

`ifdef UART_RX_PARITY_EN
    logic             par_set;
    logic             par_bad_q, par_bad_d;
    logic             pe_q, pe_d;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RXD;
            rxs_q     <= rx_meta_q;
        end
    end

    // Frame FSM state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Frame FSM next state: mid-start-bit check, then one sample per bit period
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_q == DIV_HALF) begin
                    div_d = '0;
                    bit_d = '0;
                    // A high line at mid start bit means it was only a glitch
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    state_d   = S_STOP;
                    par_bad_d = (^shift_q) ^ rxs_q;
                    par_set   = par_bad_d;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                    if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                    end else begin
                        frame_set = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when a pop frees a slot
    always_comb begin
        pop     = RD_EN && (cnt_q != '0);
        full    = (cnt_q == CNT_FULL);
        wr_en   = push && (!full || pop);
        ovr_set = push && full && !pop;
        cnt_d   = cnt_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage; contents need no reset because the count gates the output
    always_ff @(posedge CLK) begin
        if (wr_en && !RESET) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Sticky error next values: a new error event wins over a clear
    always_comb begin
        ovr_d = ovr_set   ? 1'b1 : (CLR_ERR ? 1'b0 : ovr_q);
        fe_d  = frame_set ? 1'b1 : (CLR_ERR ? 1'b0 : fe_q);
`ifdef UART_RX_PARITY_EN
        pe_d  = par_set   ? 1'b1 : (CLR_ERR ? 1'b0 : pe_q);
`endif
    end

    // Sticky error flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q      <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            ovr_q <= ovr_d;
            fe_q  <= fe_d;
`ifdef UART_RX_PARITY_EN
            pe_q      <= pe_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Interrupt request registered from the visible status, so it trails it by one cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            int_q <= 1'b0;
        end else begin
            int_q <= INT_EN & (RX_VALID | OVERRUN | FRAME_ERR | PAR_ERR);
        end
    end

    assign RX_VALID  = (cnt_q != '0);
    assign RD_DATA   = RX_VALID ? mem_q[rd_ptr_q] : 8'h00;
    assign OVERRUN   = ovr_q;
    assign FRAME_ERR = fe_q;
    assign UART_INT  = int_q;
`ifdef UART_RX_PARITY_EN
    assign PAR_ERR   = pe_q;
`else
    assign PAR_ERR   = 1'b0;
`endif

endmodule

`default_nettype wire
